multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Control FSM for the multicycle RV32I datapath.
- Sequences fetch, decode, execute, memory and writeback.
- Drives the immediate generator select, PC, register file, ALU-operand and writeback muxes.
- Handshakes with the instruction and data memories. Sits beside the immediate generator, ALU and register file in the core top.

Parameters:
- TIMEOUT, 16: max cycles waiting on a memory ready before trapping; 0 disables the timeout.
- XLEN, 32: instruction width.

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_inst  in  XLEN  current IR contents (valid from DECODE onward)
- i_br_cond  in  1  branch comparator result for the current funct3
- i_imem_ready  in  1  instruction memory data valid
- i_dmem_ready  in  1  data memory access complete
- o_imem_req  out  1  instruction fetch request
- o_dmem_req  out  1  data access request
- o_dmem_we  out  1  data write enable (store)
- o_ir_we  out  1  latch i_imem data into IR
- o_imm_sel  out  3  immediate select: 0 none, 1 I, 2 S, 3 B, 4 Jal, 5 Jalr, 6 U
- o_pc_we  out  1  PC update strobe
- o_pc_sel  out  2  next-PC source: 0 pc+4, 1 pc+imm, 2 ALU result with bit0 cleared
- o_alu_a_sel  out  1  ALU operand A source: 0 rs1, 1 pc
- o_alu_b_sel  out  1  ALU operand B source: 0 rs2, 1 imm
- o_alu_force_add  out  1  force ALU add (address calculation, auipc)
- o_rf_we  out  1  register file write strobe
- o_wb_sel  out  2  writeback source: 0 ALU, 1 memory, 2 pc+4, 3 imm (lui)
- o_illegal  out  1  sticky trap flag
- o_state  out  3  current state, for debug

Behaviour:
- Reset (async, i_rst_n=0): state=FETCH. All strobes, requests and o_illegal = 0. o_imm_sel=0. All selects=0. Timeout counter=0. Reset mid-access drops any request immediately.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
- FETCH:
  - o_imem_req=1.
  - On i_imem_ready: o_ir_we=1 for exactly that cycle, then go to DECODE.
- DECODE:
  - One cycle. Classify i_inst[6:0].
  - Opcodes 0010011/0000011 -> I; 0100011 -> S; 1100011 -> B; 1101111 -> Jal; 1100111 -> Jalr; 0110111/0010111 -> U; 0110011 -> 0; 0001111 (fence) and 1110011 (system) -> NOP.
  - Any other opcode, or i_inst[1:0]!=2'b11, goes to TRAP.
  - o_imm_sel is valid from DECODE through the final cycle of the instruction and returns to 0 in FETCH.
- EXEC: one cycle; outputs depend on instruction class.
  - ALU-reg: a=rs1, b=rs2. Go to WB.
  - ALU-imm: b=imm. Go to WB.
  - Load/store: b=imm, force_add. Go to MEM.
  - Branch: o_pc_we=1; pc_sel=1 if i_br_cond else 0. Go to FETCH.
  - Jal: pc_we, pc_sel=1. Go to WB.
  - Jalr: b=imm, force_add, pc_we, pc_sel=2. Go to WB.
  - auipc: a=pc, b=imm, force_add. Go to WB.
  - lui: go to WB.
  - NOP: pc_we, pc_sel=0. Go to FETCH.
- MEM:
  - o_dmem_req=1; o_dmem_we=1 for stores.
  - Hold until i_dmem_ready.
  - Load -> WB.
  - Store -> pc_we, pc_sel=0 in the ready cycle, then FETCH.
- WB:
  - o_rf_we=1 unless rd (i_inst[11:7])==0.
  - wb_sel: ALU for ALU/auipc, 1 for loads, 2 for jal/jalr, 3 for lui.
  - pc_we with pc_sel=0, except jal/jalr, whose PC was already written in EXEC. Then FETCH.
- Every strobe is a single-cycle pulse. Requests stay high continuously until ready.
- Ready arriving in the same cycle the request first rises is accepted (zero-wait memory).
- Latency with zero-wait memory, in cycles: R/I-ALU, U, jal, jalr = 4; load = 5; store = 4; branch and NOP = 3.
- Timeout:
  - Counter increments each cycle in FETCH/MEM while ready=0.
  - Clears on ready or on state change.
  - When TIMEOUT!=0 and the count reaches TIMEOUT: drop the request and go to TRAP.
- TRAP: o_illegal=1. All strobes and requests 0. Exit only by reset.

Decomposition:
- Shared package ctrl_pkg holds:
  - opcode constants
  - imm_sel encoding, with values shared with the immediate generator
  - state enum
  - pc_sel and wb_sel encodings
  - instruction-class enum
- One combinational sub-module, ctrl_decode: opcode -> {class, imm_sel, legal}. The FSM in multicycle_ctrl consumes it.

Test Plan:
- addi x1,x0,5 (0x00500093), zero-wait memory -> FETCH/DECODE/EXEC/WB. imm_sel=1, alu_b_sel=1, rf_we pulse in cycle 4, pc_we with pc_sel=0.
- beq taken (0x00000463, i_br_cond=1) -> imm_sel=3; pc_we and pc_sel=1 in cycle 3; no rf_we. With i_br_cond=0 -> pc_sel=0.
- lw x2,4(x1) (0x0040A103), dmem_ready delayed 3 cycles -> dmem_req held 4 cycles, dmem_we=0, wb_sel=1 rf_we pulse, 8 cycles total.
- addi x0,x0,0 (0x00000013) -> WB has rf_we=0, pc_we=1.
- Opcode 0x0000007F -> TRAP after DECODE, o_illegal=1 held. Reset clears it and returns to FETCH with imem_req=1.
- TIMEOUT=16, imem_ready held 0 -> TRAP entered after 16 FETCH cycles. Reset asserted mid-MEM -> dmem_req drops immediately and state=0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: opcodes, selects,
// FSM states and the instruction classes produced by ctrl_decode.
package ctrl_pkg;

  localparam logic [6:0] OP_ALU_I  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_ALU_R  = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Values are shared with the immediate generator.
  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_JAL  = 3'd4,
    IMM_JALR = 3'd5,
    IMM_U    = 3'd6
  } imm_sel_e;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    PC_PLUS4 = 2'd0,
    PC_IMM   = 2'd1,
    PC_ALU   = 2'd2
  } pc_sel_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_IMM = 2'd3
  } wb_sel_e;

  typedef enum logic [3:0] {
    CLS_ALU_R   = 4'd0,
    CLS_ALU_I   = 4'd1,
    CLS_LOAD    = 4'd2,
    CLS_STORE   = 4'd3,
    CLS_BRANCH  = 4'd4,
    CLS_JAL     = 4'd5,
    CLS_JALR    = 4'd6,
    CLS_AUIPC   = 4'd7,
    CLS_LUI     = 4'd8,
    CLS_NOP     = 4'd9,
    CLS_ILLEGAL = 4'd10
  } inst_class_e;

  typedef struct packed {
    inst_class_e cls;
    imm_sel_e    imm_sel;
    logic        legal;
  } decode_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control/handshake bundle between multicycle_ctrl (master) and the
// datapath plus instruction/data memories (slave).
interface multicycle_ctrl_if #(
  parameter int unsigned XLEN = 32
);
  logic [XLEN-1:0] i_inst;
  logic            i_br_cond;
  logic            i_imem_ready;
  logic            i_dmem_ready;
  logic            o_imem_req;
  logic            o_dmem_req;
  logic            o_dmem_we;
  logic            o_ir_we;
  logic [2:0]      o_imm_sel;
  logic            o_pc_we;
  logic [1:0]      o_pc_sel;
  logic            o_alu_a_sel;
  logic            o_alu_b_sel;
  logic            o_alu_force_add;
  logic            o_rf_we;
  logic [1:0]      o_wb_sel;
  logic            o_illegal;
  logic [2:0]      o_state;

  modport master (
    input  i_inst, i_br_cond, i_imem_ready, i_dmem_ready,
    output o_imem_req, o_dmem_req, o_dmem_we, o_ir_we, o_imm_sel,
           o_pc_we, o_pc_sel, o_alu_a_sel, o_alu_b_sel, o_alu_force_add,
           o_rf_we, o_wb_sel, o_illegal, o_state
  );

  modport slave (
    output i_inst, i_br_cond, i_imem_ready, i_dmem_ready,
    input  o_imem_req, o_dmem_req, o_dmem_we, o_ir_we, o_imm_sel,
           o_pc_we, o_pc_sel, o_alu_a_sel, o_alu_b_sel, o_alu_force_add,
           o_rf_we, o_wb_sel, o_illegal, o_state
  );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational opcode classifier: opcode -> instruction class, immediate
// select and legality. The full 7-bit match also rejects inst[1:0] != 2'b11.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output decode_t    dec
);

  always_comb begin
    dec = '{cls: CLS_ILLEGAL, imm_sel: IMM_NONE, legal: 1'b0};
    case (opcode)
      OP_ALU_I:  dec = '{cls: CLS_ALU_I,  imm_sel: IMM_I,    legal: 1'b1};
      OP_LOAD:   dec = '{cls: CLS_LOAD,   imm_sel: IMM_I,    legal: 1'b1};
      OP_STORE:  dec = '{cls: CLS_STORE,  imm_sel: IMM_S,    legal: 1'b1};
      OP_BRANCH: dec = '{cls: CLS_BRANCH, imm_sel: IMM_B,    legal: 1'b1};
      OP_JAL:    dec = '{cls: CLS_JAL,    imm_sel: IMM_JAL,  legal: 1'b1};
      OP_JALR:   dec = '{cls: CLS_JALR,   imm_sel: IMM_JALR, legal: 1'b1};
      OP_LUI:    dec = '{cls: CLS_LUI,    imm_sel: IMM_U,    legal: 1'b1};
      OP_AUIPC:  dec = '{cls: CLS_AUIPC,  imm_sel: IMM_U,    legal: 1'b1};
      OP_ALU_R:  dec = '{cls: CLS_ALU_R,  imm_sel: IMM_NONE, legal: 1'b1};
      OP_FENCE,
      OP_SYSTEM: dec = '{cls: CLS_NOP,    imm_sel: IMM_NONE, legal: 1'b1};
      default:   dec = '{cls: CLS_ILLEGAL, imm_sel: IMM_NONE, legal: 1'b0};
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Control FSM for the multicycle RV32I datapath: fetch, decode, execute,
// memory and writeback sequencing with memory-ready timeout trapping.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned XLEN    = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  multicycle_ctrl_if.master bus
);

  localparam int unsigned      CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  inst;
  decode_t          dec;
  logic             rd_nz;
  logic             waiting;
  logic             to_hit;

  logic             imem_req, dmem_req, dmem_we, ir_we;
  logic [2:0]       imm_sel;
  logic             pc_we;
  logic [1:0]       pc_sel;
  logic             alu_a_sel, alu_b_sel, alu_force_add;
  logic             rf_we;
  logic [1:0]       wb_sel;
  logic             illegal;

  assign inst  = bus.i_inst;
  assign rd_nz = |inst[11:7];

  ctrl_decode u_decode (
    .opcode (inst[6:0]),
    .dec    (dec)
  );

  always_comb begin
    waiting = 1'b0;
    case (state_q)
      ST_FETCH: waiting = !bus.i_imem_ready;
      ST_MEM:   waiting = !bus.i_dmem_ready;
      default:  waiting = 1'b0;
    endcase
  end

  assign to_hit = (TIMEOUT != 0) && waiting && (cnt_q == CNT_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if ((state_d != state_q) || !waiting || (TIMEOUT == 0))
        cnt_q <= '0;
      else
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d       = state_q;
    imem_req      = 1'b0;
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    ir_we         = 1'b0;
    imm_sel       = IMM_NONE;
    pc_we         = 1'b0;
    pc_sel        = PC_PLUS4;
    alu_a_sel     = 1'b0;
    alu_b_sel     = 1'b0;
    alu_force_add = 1'b0;
    rf_we         = 1'b0;
    wb_sel        = WB_ALU;
    illegal       = 1'b0;

    if (state_q inside {ST_DECODE, ST_EXEC, ST_MEM, ST_WB})
      imm_sel = dec.imm_sel;

    case (state_q)
      // Reset parks the FSM in FETCH, so only the fetch outputs need the
      // reset gate to keep the bus quiet while i_rst_n is low.
      ST_FETCH: begin
        imem_req = i_rst_n;
        if (bus.i_imem_ready) begin
          ir_we   = i_rst_n;
          state_d = ST_DECODE;
        end else if (to_hit) begin
          state_d = ST_TRAP;
        end
      end

      ST_DECODE: state_d = dec.legal ? ST_EXEC : ST_TRAP;

      ST_EXEC: begin
        case (dec.cls)
          CLS_ALU_R: state_d = ST_WB;
          CLS_ALU_I: begin
            alu_b_sel = 1'b1;
            state_d   = ST_WB;
          end
          CLS_LOAD, CLS_STORE: begin
            alu_b_sel     = 1'b1;
            alu_force_add = 1'b1;
            state_d       = ST_MEM;
          end
          CLS_BRANCH: begin
            pc_we   = 1'b1;
            pc_sel  = bus.i_br_cond ? PC_IMM : PC_PLUS4;
            state_d = ST_FETCH;
          end
          CLS_JAL: begin
            pc_we   = 1'b1;
            pc_sel  = PC_IMM;
            state_d = ST_WB;
          end
          CLS_JALR: begin
            alu_b_sel     = 1'b1;
            alu_force_add = 1'b1;
            pc_we         = 1'b1;
            pc_sel        = PC_ALU;
            state_d       = ST_WB;
          end
          CLS_AUIPC: begin
            alu_a_sel     = 1'b1;
            alu_b_sel     = 1'b1;
            alu_force_add = 1'b1;
            state_d       = ST_WB;
          end
          CLS_LUI: state_d = ST_WB;
          CLS_NOP: begin
            pc_we   = 1'b1;
            pc_sel  = PC_PLUS4;
            state_d = ST_FETCH;
          end
          default: state_d = ST_TRAP;
        endcase
      end

      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (dec.cls == CLS_STORE);
        if (bus.i_dmem_ready) begin
          if (dec.cls == CLS_STORE) begin
            pc_we   = 1'b1;
            pc_sel  = PC_PLUS4;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else if (to_hit) begin
          state_d = ST_TRAP;
        end
      end

      ST_WB: begin
        rf_we = rd_nz;
        case (dec.cls)
          CLS_LOAD:          wb_sel = WB_MEM;
          CLS_JAL, CLS_JALR: wb_sel = WB_PC4;
          CLS_LUI:           wb_sel = WB_IMM;
          default:           wb_sel = WB_ALU;
        endcase
        // Jumps already wrote the PC in EXEC.
        pc_we   = !(dec.cls inside {CLS_JAL, CLS_JALR});
        pc_sel  = PC_PLUS4;
        state_d = ST_FETCH;
      end

      ST_TRAP: illegal = 1'b1;

      default: state_d = ST_TRAP;
    endcase
  end

  assign bus.o_imem_req      = imem_req;
  assign bus.o_dmem_req      = dmem_req;
  assign bus.o_dmem_we       = dmem_we;
  assign bus.o_ir_we         = ir_we;
  assign bus.o_imm_sel       = imm_sel;
  assign bus.o_pc_we         = pc_we;
  assign bus.o_pc_sel        = pc_sel;
  assign bus.o_alu_a_sel     = alu_a_sel;
  assign bus.o_alu_b_sel     = alu_b_sel;
  assign bus.o_alu_force_add = alu_force_add;
  assign bus.o_rf_we         = rf_we;
  assign bus.o_wb_sel        = wb_sel;
  assign bus.o_illegal       = illegal;
  assign bus.o_state         = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expected control vectors are
// queued from an instruction-level model and compared cycle by cycle.
module tb_multicycle_ctrl;

  localparam int unsigned TO = 16;

  localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_JAL = 5;
  localparam int K_JALR = 6, K_AUI = 7, K_LUI = 8, K_NOP = 9, K_BAD = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_ctrl_if #(.XLEN(32)) bus ();

  multicycle_ctrl #(.TIMEOUT(TO), .XLEN(32)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic [2:0] state;
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic       ir_we;
    logic [2:0] imm_sel;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       a_sel;
    logic       b_sel;
    logic       force_add;
    logic       rf_we;
    logic [1:0] wb_sel;
    logic       illegal;
  } obs_t;

  typedef struct {
    logic        imem_rdy;
    logic        dmem_rdy;
    logic [31:0] inst;
    logic        br;
    obs_t        exp;
  } step_t;

  step_t       sb[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  function automatic obs_t sample();
    obs_t o;
    o.state     = bus.o_state;
    o.imem_req  = bus.o_imem_req;
    o.dmem_req  = bus.o_dmem_req;
    o.dmem_we   = bus.o_dmem_we;
    o.ir_we     = bus.o_ir_we;
    o.imm_sel   = bus.o_imm_sel;
    o.pc_we     = bus.o_pc_we;
    o.pc_sel    = bus.o_pc_sel;
    o.a_sel     = bus.o_alu_a_sel;
    o.b_sel     = bus.o_alu_b_sel;
    o.force_add = bus.o_alu_force_add;
    o.rf_we     = bus.o_rf_we;
    o.wb_sel    = bus.o_wb_sel;
    o.illegal   = bus.o_illegal;
    return o;
  endfunction

  function automatic obs_t idle(input logic [2:0] st);
    obs_t o = '0;
    o.state = st;
    return o;
  endfunction

  task automatic push(input logic ir, input logic dr, input logic [31:0] inst,
                      input logic br, input obs_t e);
    step_t s;
    s.imem_rdy = ir;
    s.dmem_rdy = dr;
    s.inst     = inst;
    s.br       = br;
    s.exp      = e;
    sb.push_back(s);
  endtask

  // Instruction-level model: waits of TO or more cycles mean the memory never answers.
  task automatic queue_instr(input logic [31:0] inst, input logic br,
                             input int unsigned iw, input int unsigned dw);
    obs_t       e;
    int         k;
    logic [2:0] imm;
    logic       rdnz;
    rdnz = |inst[11:7];
    case (inst[6:0])
      7'b0010011: begin k = K_I;    imm = 3'd1; end
      7'b0000011: begin k = K_LD;   imm = 3'd1; end
      7'b0100011: begin k = K_ST;   imm = 3'd2; end
      7'b1100011: begin k = K_BR;   imm = 3'd3; end
      7'b1101111: begin k = K_JAL;  imm = 3'd4; end
      7'b1100111: begin k = K_JALR; imm = 3'd5; end
      7'b0110111: begin k = K_LUI;  imm = 3'd6; end
      7'b0010111: begin k = K_AUI;  imm = 3'd6; end
      7'b0110011: begin k = K_R;    imm = 3'd0; end
      7'b0001111, 7'b1110011: begin k = K_NOP; imm = 3'd0; end
      default:    begin k = K_BAD;  imm = 3'd0; end
    endcase

    for (int unsigned c = 0; c < iw && c < TO; c++) begin
      e = idle(3'd0); e.imem_req = 1'b1;
      push(1'b0, 1'b1, inst, br, e);
    end
    if (iw >= TO) begin
      e = idle(3'd7); e.illegal = 1'b1;
      repeat (3) push(1'b1, 1'b1, inst, br, e);
      return;
    end
    e = idle(3'd0); e.imem_req = 1'b1; e.ir_we = 1'b1;
    push(1'b1, 1'b0, inst, br, e);

    e = idle(3'd1); e.imm_sel = imm;
    push(1'b1, 1'b1, inst, br, e);
    if (k == K_BAD) begin
      e = idle(3'd7); e.illegal = 1'b1;
      repeat (3) push(1'b1, 1'b1, inst, br, e);
      return;
    end

    e = idle(3'd2); e.imm_sel = imm;
    case (k)
      K_I:         e.b_sel = 1'b1;
      K_LD, K_ST:  begin e.b_sel = 1'b1; e.force_add = 1'b1; end
      K_BR:        begin e.pc_we = 1'b1; e.pc_sel = br ? 2'd1 : 2'd0; end
      K_JAL:       begin e.pc_we = 1'b1; e.pc_sel = 2'd1; end
      K_JALR:      begin e.b_sel = 1'b1; e.force_add = 1'b1; e.pc_we = 1'b1; e.pc_sel = 2'd2; end
      K_AUI:       begin e.a_sel = 1'b1; e.b_sel = 1'b1; e.force_add = 1'b1; end
      K_NOP:       e.pc_we = 1'b1;
      default:     ;
    endcase
    push(1'b1, 1'b1, inst, br, e);

    if (k == K_LD || k == K_ST) begin
      for (int unsigned c = 0; c < dw && c < TO; c++) begin
        e = idle(3'd3); e.imm_sel = imm; e.dmem_req = 1'b1; e.dmem_we = (k == K_ST);
        push(1'b1, 1'b0, inst, br, e);
      end
      if (dw >= TO) begin
        e = idle(3'd7); e.illegal = 1'b1;
        repeat (3) push(1'b1, 1'b1, inst, br, e);
        return;
      end
      e = idle(3'd3); e.imm_sel = imm; e.dmem_req = 1'b1; e.dmem_we = (k == K_ST);
      if (k == K_ST) e.pc_we = 1'b1;
      push(1'b1, 1'b1, inst, br, e);
    end

    if (!(k == K_BR || k == K_NOP || k == K_ST)) begin
      e = idle(3'd4); e.imm_sel = imm; e.rf_we = rdnz;
      case (k)
        K_LD:          e.wb_sel = 2'd1;
        K_JAL, K_JALR: e.wb_sel = 2'd2;
        K_LUI:         e.wb_sel = 2'd3;
        default:       e.wb_sel = 2'd0;
      endcase
      e.pc_we = !(k == K_JAL || k == K_JALR);
      push(1'b1, 1'b1, inst, br, e);
    end
  endtask

  // Pops one queued cycle, drives its inputs, samples mid-cycle, then advances.
  task automatic step(output obs_t got, output obs_t exp);
    step_t s;
    s = sb.pop_front();
    bus.i_imem_ready = s.imem_rdy;
    bus.i_dmem_ready = s.dmem_rdy;
    bus.i_inst       = s.inst;
    bus.i_br_cond    = s.br;
    #3;
    got = sample();
    exp = s.exp;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.i_imem_ready = 1'b0;
    bus.i_dmem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    obs_t got;
    bus.i_inst = 32'h0;
    bus.i_br_cond = 1'b0;
    bus.i_imem_ready = 1'b0;
    bus.i_dmem_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    got = sample();
    n_cmp++;
    if (got !== obs_t'(0)) begin
      n_bad++; $display("FAIL reset_idle: got %h exp %h", got, obs_t'(0));
    end
    bus.i_imem_ready = 1'b1;
    bus.i_dmem_ready = 1'b1;
    #1;
    got = sample();
    n_cmp++;
    if (got !== obs_t'(0)) begin
      n_bad++; $display("FAIL reset_ready_ignored: got %h exp %h", got, obs_t'(0));
    end
    @(posedge clk);
    #1;
    bus.i_imem_ready = 1'b0;
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (bus.o_imem_req !== 1'b1 || bus.o_state !== 3'd0) begin
      n_bad++; $display("FAIL reset_release: imem_req %b state %0d exp 1/0", bus.o_imem_req, bus.o_state);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_alu();
    obs_t got, exp;
    int   i = 0;
    queue_instr(32'h00500093, 1'b0, 0, 0);  // addi x1,x0,5
    queue_instr(32'h002081B3, 1'b1, 2, 0);  // add x3,x1,x2
    queue_instr(32'h00000013, 1'b0, 0, 0);  // addi x0,x0,0
    queue_instr(32'h00001317, 1'b0, 1, 0);  // auipc x6,1
    queue_instr(32'h123452B7, 1'b0, 0, 0);  // lui x5,0x12345
    while (sb.size() != 0) begin
      step(got, exp);
      n_cmp++;
      if (got !== exp) begin
        n_bad++; $display("FAIL alu cyc %0d: got %h exp %h", i, got, exp);
      end
      i++;
    end
  endtask

  task automatic test_branch();
    obs_t got, exp;
    int   i = 0;
    queue_instr(32'h00000463, 1'b1, 0, 0);
    queue_instr(32'h00000463, 1'b0, 0, 0);
    while (sb.size() != 0) begin
      step(got, exp);
      n_cmp++;
      if (got !== exp) begin
        n_bad++; $display("FAIL branch cyc %0d: got %h exp %h", i, got, exp);
      end
      i++;
    end
  endtask

  task automatic test_load_store();
    obs_t got, exp;
    int   i = 0;
    queue_instr(32'h0040A103, 1'b0, 0, 3);   // lw x2,4(x1), 3 wait cycles
    queue_instr(32'h0020A423, 1'b0, 0, 0);   // sw x2,8(x1)
    queue_instr(32'h0020A423, 1'b0, 0, 2);
    queue_instr(32'h0040A103, 1'b0, 0, 0);
    queue_instr(32'h0040A103, 1'b0, 0, 15);  // last wait before the timeout
    while (sb.size() != 0) begin
      step(got, exp);
      n_cmp++;
      if (got !== exp) begin
        n_bad++; $display("FAIL ldst cyc %0d: got %h exp %h", i, got, exp);
      end
      i++;
    end
  endtask

  task automatic test_jumps();
    obs_t got, exp;
    int   i = 0;
    queue_instr(32'h008000EF, 1'b0, 0, 0);  // jal x1,8
    queue_instr(32'h00008067, 1'b1, 0, 0);  // jalr x0,0(x1)
    while (sb.size() != 0) begin
      step(got, exp);
      n_cmp++;
      if (got !== exp) begin
        n_bad++; $display("FAIL jump cyc %0d: got %h exp %h", i, got, exp);
      end
      i++;
    end
  endtask

  task automatic test_nop();
    obs_t got, exp;
    int   i = 0;
    queue_instr(32'h0000000F, 1'b1, 0, 0);  // fence
    queue_instr(32'h00000073, 1'b0, 1, 0);  // ecall
    while (sb.size() != 0) begin
      step(got, exp);
      n_cmp++;
      if (got !== exp) begin
        n_bad++; $display("FAIL nop cyc %0d: got %h exp %h", i, got, exp);
      end
      i++;
    end
  endtask

  task automatic test_back_to_back();
    obs_t        got, exp;
    int          i = 0;
    logic [31:0] prog [10];
    prog = '{32'h00500093, 32'h0040A103, 32'h00000463, 32'h0020A423, 32'h008000EF,
             32'h00008067, 32'h123452B7, 32'h00001317, 32'h002081B3, 32'h00000073};
    for (int n = 0; n < 20; n++)
      queue_instr(prog[$urandom_range(0, 9)], 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3), $urandom_range(0, 3));
    while (sb.size() != 0) begin
      step(got, exp);
      n_cmp++;
      if (got !== exp) begin
        n_bad++; $display("FAIL b2b cyc %0d: got %h exp %h", i, got, exp);
      end
      i++;
    end
  endtask

  task automatic test_illegal();
    obs_t got, exp;
    int   i = 0;
    queue_instr(32'h0000007F, 1'b0, 0, 0);
    while (sb.size() != 0) begin
      step(got, exp);
      n_cmp++;
      if (got !== exp) begin
        n_bad++; $display("FAIL illegal_op cyc %0d: got %h exp %h", i, got, exp);
      end
      i++;
    end
    apply_reset();
    #1;
    n_cmp++;
    if (bus.o_illegal !== 1'b0 || bus.o_imem_req !== 1'b1 || bus.o_state !== 3'd0) begin
      n_bad++;
      $display("FAIL illegal_clear: illegal %b imem_req %b state %0d exp 0/1/0",
               bus.o_illegal, bus.o_imem_req, bus.o_state);
    end
    @(posedge clk);
    #1;
    queue_instr(32'h00000012, 1'b0, 0, 0);  // inst[1:0] = 2'b10
    while (sb.size() != 0) begin
      step(got, exp);
      n_cmp++;
      if (got !== exp) begin
        n_bad++; $display("FAIL illegal_lowbits cyc %0d: got %h exp %h", i, got, exp);
      end
      i++;
    end
    apply_reset();
  endtask

  task automatic test_timeout();
    obs_t got, exp;
    int   i = 0;
    queue_instr(32'h00500093, 1'b0, 15, 0);  // ready on the 16th fetch cycle
    queue_instr(32'h00500093, 1'b0, TO, 0);  // never ready: trap
    while (sb.size() != 0) begin
      step(got, exp);
      n_cmp++;
      if (got !== exp) begin
        n_bad++; $display("FAIL fetch_timeout cyc %0d: got %h exp %h", i, got, exp);
      end
      i++;
    end
    apply_reset();
    queue_instr(32'h0020A423, 1'b0, 0, TO);  // store never acknowledged
    while (sb.size() != 0) begin
      step(got, exp);
      n_cmp++;
      if (got !== exp) begin
        n_bad++; $display("FAIL mem_timeout cyc %0d: got %h exp %h", i, got, exp);
      end
      i++;
    end
    apply_reset();
  endtask

  task automatic test_reset_mid_mem();
    bus.i_inst = 32'h0040A103;
    bus.i_imem_ready = 1'b1;
    bus.i_dmem_ready = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    bus.i_imem_ready = 1'b0;
    #2;
    n_cmp++;
    if (bus.o_dmem_req !== 1'b1 || bus.o_state !== 3'd3) begin
      n_bad++; $display("FAIL mid_mem_pre: dmem_req %b state %0d exp 1/3", bus.o_dmem_req, bus.o_state);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.o_dmem_req !== 1'b0 || bus.o_state !== 3'd0 || bus.o_imem_req !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_mem_reset: dmem_req %b state %0d imem_req %b exp 0/0/0",
               bus.o_dmem_req, bus.o_state, bus.o_imem_req);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (bus.o_imem_req !== 1'b1 || bus.o_state !== 3'd0) begin
      n_bad++; $display("FAIL mid_mem_release: imem_req %b state %0d exp 1/0", bus.o_imem_req, bus.o_state);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_branch();
    test_load_store();
    test_jumps();
    test_nop();
    test_back_to_back();
    test_illegal();
    test_timeout();
    test_reset_mid_mem();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
